// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues I-cache requests and loads the F/D register.
// Redirects and halts seen during an outstanding miss are deferred until it completes.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  input  logic        halt_PC,
  input  logic        imem_rdy,
  input  logic [15:0] imem_instr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [31:0] D_out,
  output logic        fd_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_REDIR,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        hpend_q, hpend_d;
  logic [15:0] rpc_q, rpc_d;
  logic [15:0] pc_inc;
  logic [31:0] bubble;

  assign pc_inc = pc_q + 16'd2;
  assign bubble = {pc_inc, NOP_INSTR};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    hpend_d = hpend_q;
    rpc_d   = rpc_q;
    if (stall) begin
      // the word delivered under a stall is refetched as a hit
      if (state_q == S_WAIT && imem_rdy)
        state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          dout_d  = bubble;
          valid_d = 1'b0;
          if (imem_rdy) begin
            state_d = S_FETCH;
            if (hpend_q) begin
              state_d = S_HALTED;
            end else if (flush) begin
              pc_d = branch_target;
            end else if (halt_PC) begin
              state_d = S_HALTED;
            end else begin
              pc_d    = pc_inc;
              dout_d  = {pc_inc, imem_instr};
              valid_d = 1'b1;
            end
          end else if (flush) begin
            // a redirect supersedes any halt seen earlier in the miss
            rpc_d   = branch_target;
            hpend_d = 1'b0;
            state_d = S_REDIR;
          end else begin
            if (halt_PC)
              hpend_d = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_REDIR: begin
          dout_d  = bubble;
          valid_d = 1'b0;
          if (imem_rdy) begin
            pc_d    = rpc_q;
            state_d = S_FETCH;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      dout_q  <= {16'h0000, NOP_INSTR};
      valid_q <= 1'b0;
      hpend_q <= 1'b0;
      rpc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      hpend_q <= hpend_d;
      rpc_q   <= rpc_d;
    end
  end

  assign imem_req  = (state_q != S_HALTED);
  assign imem_addr = pc_q;
  assign D_out     = dout_q;
  assign fd_valid  = valid_q;
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal sequences plus randomized
// traffic against a flag-based reference model and a latency-driven I-cache.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, halt_PC, imem_rdy;
  logic [15:0] branch_target, imem_instr;
  logic        imem_req, fd_valid, halted;
  logic [15:0] imem_addr;
  logic [31:0] D_out;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(branch_target), .halt_PC(halt_PC),
    .imem_rdy(imem_rdy), .imem_instr(imem_instr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .D_out(D_out), .fd_valid(fd_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: architectural view only
  logic [15:0] m_pc;
  logic [31:0] m_d;
  logic        m_v, m_halted, m_hpend, m_redir_v;
  logic [15:0] m_redir;

  // I-cache environment
  logic [15:0] env_addr;
  bit          env_fresh;
  int          env_wait;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_d = 32'h0; m_v = 1'b0;
    m_halted = 1'b0; m_hpend = 1'b0;
    m_redir_v = 1'b0; m_redir = 16'h0;
    env_fresh = 1'b1;
  endtask

  task automatic model_step();
    logic [15:0] nxt;
    nxt = m_pc + 16'd2;
    if (!m_halted && !stall) begin
      m_d = {nxt, 16'h0000};
      m_v = 1'b0;
      if (imem_rdy) begin
        if (m_redir_v) begin
          m_pc = m_redir; m_redir_v = 1'b0;
        end else if (m_hpend) m_halted = 1'b1;
        else if (flush) m_pc = branch_target;
        else if (halt_PC) m_halted = 1'b1;
        else begin
          m_d = {nxt, imem_instr}; m_v = 1'b1; m_pc = nxt;
        end
      end else if (!m_redir_v) begin
        if (flush) begin
          m_redir = branch_target; m_redir_v = 1'b1; m_hpend = 1'b0;
        end else if (halt_PC) m_hpend = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(!m_halted));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("D_out", D_out, m_d);
    chk("fd_valid", 32'(fd_valid), 32'(m_v));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_in(bit st, bit fl, logic [15:0] bt, bit hl,
                        bit rd, logic [15:0] ins);
    stall = st; flush = fl; branch_target = bt;
    halt_PC = hl; imem_rdy = rd; imem_instr = ins;
  endtask

  task automatic env_drive();
    if (env_fresh || imem_addr != env_addr) begin
      env_addr = imem_addr;
      env_fresh = 1'b0;
      env_wait = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    end
    imem_rdy = (env_wait == 0);
    if (env_wait > 0) env_wait--;
    imem_instr = imem_rdy ? ((env_addr * 16'h9E37) ^ 16'h1234) : 16'($urandom);
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    halt_PC = ($urandom_range(0, 199) == 0);
    branch_target = 16'($urandom) & 16'hFFFE;
    if ($urandom_range(0, 7) == 0) branch_target = 16'hFFFA;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_addr", 32'(imem_addr), 32'h0000);
    chk("rst_valid", 32'(fd_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 16'h0, 0, 0, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset D_out", D_out, 32'h0000_0000);
    chk("reset req", 32'(imem_req), 32'h1);
    compare();

    // sequential fetch
    set_in(0, 0, 16'h0, 0, 1, 16'hAAAA); tick();
    chk("seq A", D_out, 32'h0002_AAAA);
    chk("seq A addr", 32'(imem_addr), 32'h0002);
    set_in(0, 0, 16'h0, 0, 1, 16'hBBBB); tick();
    chk("seq B", D_out, 32'h0004_BBBB);
    set_in(0, 0, 16'h0, 0, 1, 16'hCCCC); tick();
    chk("seq C", D_out, 32'h0006_CCCC);
    chk("seq C addr", 32'(imem_addr), 32'h0006);
    chk("seq valid", 32'(fd_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 16'h0, 0, 1, 16'h0101); tick();
    end
    chk("pc 0x10", 32'(imem_addr), 32'h0010);

    // flush on a hit
    set_in(0, 1, 16'h0040, 0, 1, 16'h0F0F); tick();
    chk("flush addr", 32'(imem_addr), 32'h0040);
    chk("flush D", D_out, 32'h0012_0000);
    chk("flush valid", 32'(fd_valid), 32'h0);
    set_in(0, 0, 16'h0, 0, 1, 16'h4444); tick();
    chk("after flush", D_out, 32'h0042_4444);

    // stall beats flush
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 16'h0700, 0, 1, 16'h9999); tick();
      chk("stall D", D_out, 32'h0042_4444);
      chk("stall addr", 32'(imem_addr), 32'h0042);
    end
    set_in(0, 0, 16'h0, 0, 1, 16'h5555); tick();
    chk("post stall", D_out, 32'h0044_5555);

    // miss with flush in its first cycle
    set_in(0, 1, 16'h0080, 0, 0, 16'hBAD0); tick();
    chk("miss addr1", 32'(imem_addr), 32'h0044);
    set_in(0, 0, 16'h0, 0, 0, 16'hBAD1); tick();
    set_in(0, 0, 16'h0, 0, 0, 16'hBAD2); tick();
    chk("miss addr3", 32'(imem_addr), 32'h0044);
    set_in(0, 0, 16'h0, 0, 1, 16'hDEAD); tick();
    chk("redir addr", 32'(imem_addr), 32'h0080);
    chk("redir valid", 32'(fd_valid), 32'h0);
    set_in(0, 0, 16'h0, 0, 1, 16'h8888); tick();
    chk("redir D", D_out, 32'h0082_8888);

    // halt on a hit
    set_in(0, 0, 16'h0, 1, 1, 16'h7777); tick();
    chk("halt", 32'(halted), 32'h1);
    chk("halt req", 32'(imem_req), 32'h0);
    chk("halt addr", 32'(imem_addr), 32'h0082);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 16'h0200, 0, 1, 16'h1234); tick();
    end
    chk("halt held", 32'(imem_addr), 32'h0082);

    // halt during a 2-cycle miss
    async_reset();
    set_in(0, 0, 16'h0, 1, 0, 16'h0); tick();
    chk("hmiss halted", 32'(halted), 32'h0);
    set_in(0, 0, 16'h0, 0, 0, 16'h0); tick();
    chk("hmiss addr", 32'(imem_addr), 32'h0000);
    set_in(0, 0, 16'h0, 0, 1, 16'h6666); tick();
    chk("hmiss halt", 32'(halted), 32'h1);

    // reset during a deferred redirect drops it
    async_reset();
    set_in(0, 0, 16'h0, 0, 1, 16'h1111); tick();
    set_in(0, 1, 16'h0300, 0, 0, 16'h0); tick();
    set_in(0, 0, 16'h0, 0, 0, 16'h0); tick();
    async_reset();
    set_in(0, 0, 16'h0, 0, 1, 16'h2222); tick();
    chk("rst drop redir", D_out, 32'h0002_2222);

    // randomized traffic
    for (int ep = 0; ep < 16; ep++) begin
      async_reset();
      for (int c = 0; c < 300; c++) begin
        env_drive();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
